// File: rtl/midi_decoder_if.sv
// Byte-in / event-out bundle between the MIDI UART receiver, the decoder and the voice allocator.
// The master side drives received bytes and channel selection; the slave side (decoder) drives the decoded events.
interface midi_decoder_if;
  logic        ce;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  midi_channel;
  logic        omni;
  logic [6:0]  note_num;
  logic [6:0]  note_vel;
  logic        note_on;
  logic        note_off;
  logic [6:0]  cc_num;
  logic [6:0]  cc_val;
  logic        cc_strobe;
  logic [13:0] pitch_bend;

  modport master (
    output ce, rx_data, rx_valid, midi_channel, omni,
    input  note_num, note_vel, note_on, note_off, cc_num, cc_val, cc_strobe, pitch_bend
  );

  modport slave (
    input  ce, rx_data, rx_valid, midi_channel, omni,
    output note_num, note_vel, note_on, note_off, cc_num, cc_val, cc_strobe, pitch_bend
  );
endinterface

// File: rtl/midi_decoder.sv
// MIDI channel-voice decoder with running status: Note On/Off, Control Change and Pitch Bend
// for one channel or omni; real-time bytes pass through without disturbing a partial message.
module midi_decoder (
  input  logic           clk,
  input  logic           rst,
  midi_decoder_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_DATA1, S_DATA2} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_type, w_type_nxt;
  logic        r_match, w_match_nxt;
  logic [6:0]  r_d1, w_d1_nxt;
  logic [6:0]  r_note_num, w_note_num_nxt;
  logic [6:0]  r_note_vel, w_note_vel_nxt;
  logic        r_note_on, w_note_on_nxt;
  logic        r_note_off, w_note_off_nxt;
  logic [6:0]  r_cc_num, w_cc_num_nxt;
  logic [6:0]  r_cc_val, w_cc_val_nxt;
  logic        r_cc_strobe, w_cc_strobe_nxt;
  logic [13:0] r_pitch_bend, w_pitch_bend_nxt;
  logic [6:0]  w_d2;

  assign w_d2 = bus.rx_data[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_type       <= '0;
      r_match      <= 1'b0;
      r_d1         <= '0;
      r_note_num   <= '0;
      r_note_vel   <= '0;
      r_note_on    <= 1'b0;
      r_note_off   <= 1'b0;
      r_cc_num     <= '0;
      r_cc_val     <= '0;
      r_cc_strobe  <= 1'b0;
      r_pitch_bend <= 14'h2000;
    end else if (bus.ce) begin
      r_state      <= w_state_nxt;
      r_type       <= w_type_nxt;
      r_match      <= w_match_nxt;
      r_d1         <= w_d1_nxt;
      r_note_num   <= w_note_num_nxt;
      r_note_vel   <= w_note_vel_nxt;
      r_note_on    <= w_note_on_nxt;
      r_note_off   <= w_note_off_nxt;
      r_cc_num     <= w_cc_num_nxt;
      r_cc_val     <= w_cc_val_nxt;
      r_cc_strobe  <= w_cc_strobe_nxt;
      r_pitch_bend <= w_pitch_bend_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_type_nxt       = r_type;
    w_match_nxt      = r_match;
    w_d1_nxt         = r_d1;
    w_note_num_nxt   = r_note_num;
    w_note_vel_nxt   = r_note_vel;
    w_note_on_nxt    = 1'b0;
    w_note_off_nxt   = 1'b0;
    w_cc_num_nxt     = r_cc_num;
    w_cc_val_nxt     = r_cc_val;
    w_cc_strobe_nxt  = 1'b0;
    w_pitch_bend_nxt = r_pitch_bend;

    if (bus.rx_valid) begin
      if (bus.rx_data[7:3] == 5'b11111) begin
        // real-time: leave everything, including any partial message, untouched
      end else if (bus.rx_data[7:4] == 4'hF) begin
        w_state_nxt = S_IDLE;
      end else if (bus.rx_data[7]) begin
        w_type_nxt  = bus.rx_data[6:4];
        w_match_nxt = bus.omni | (bus.rx_data[3:0] == bus.midi_channel);
        w_state_nxt = S_DATA1;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_DATA1: begin
            w_d1_nxt = bus.rx_data[6:0];
            // Program Change / Channel Pressure complete here but drive no outputs
            if (r_type != 3'h4 && r_type != 3'h5) w_state_nxt = S_DATA2;
          end
          S_DATA2: begin
            w_state_nxt = S_DATA1;
            if (r_match) begin
              unique case (r_type)
                3'h1: begin
                  w_note_num_nxt = r_d1;
                  w_note_vel_nxt = w_d2;
                  w_note_on_nxt  = (w_d2 != 7'd0);
                  w_note_off_nxt = (w_d2 == 7'd0);
                end
                3'h0: begin
                  w_note_num_nxt = r_d1;
                  w_note_vel_nxt = '0;
                  w_note_off_nxt = 1'b1;
                end
                3'h3: begin
                  w_cc_num_nxt    = r_d1;
                  w_cc_val_nxt    = w_d2;
                  w_cc_strobe_nxt = 1'b1;
                end
                3'h6: w_pitch_bend_nxt = {w_d2, r_d1};
                default: ;
              endcase
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  assign bus.note_num   = r_note_num;
  assign bus.note_vel   = r_note_vel;
  assign bus.note_on    = r_note_on;
  assign bus.note_off   = r_note_off;
  assign bus.cc_num     = r_cc_num;
  assign bus.cc_val     = r_cc_val;
  assign bus.cc_strobe  = r_cc_strobe;
  assign bus.pitch_bend = r_pitch_bend;
endmodule
